// File: rtl/mem_write_ctrl_if.sv
// Stream bundle for mem_write_ctrl: the s01 input stream and the m01 memory write stream.
// The slave modport is the controller's view; the master modport is the surrounding system's view.
interface mem_write_ctrl_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) ();
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] s01_axis_tdata;
   logic [STRB_WIDTH-1:0] s01_axis_tstrb;
   logic                  s01_axis_tvalid;
   logic                  s01_axis_tlast;
   logic                  s01_axis_tready;

   logic                  m01_axis_wr_en;
   logic [ADDR_WIDTH-1:0] m01_axis_wr_addr;
   logic [DATA_WIDTH-1:0] m01_axis_wr_tdata;
   logic [STRB_WIDTH-1:0] m01_axis_tstrb;
   logic                  m01_axis_tvalid;
   logic                  m01_axis_tlast;
   logic                  m01_axis_tready;

   modport slave (
      input  s01_axis_tdata, s01_axis_tstrb, s01_axis_tvalid, s01_axis_tlast,
      output s01_axis_tready,
      output m01_axis_wr_en, m01_axis_wr_addr, m01_axis_wr_tdata, m01_axis_tstrb,
      output m01_axis_tvalid, m01_axis_tlast,
      input  m01_axis_tready
   );

   modport master (
      output s01_axis_tdata, s01_axis_tstrb, s01_axis_tvalid, s01_axis_tlast,
      input  s01_axis_tready,
      input  m01_axis_wr_en, m01_axis_wr_addr, m01_axis_wr_tdata, m01_axis_tstrb,
      input  m01_axis_tvalid, m01_axis_tlast,
      output m01_axis_tready
   );
endinterface

// File: rtl/mem_write_ctrl.sv
// Upstream write controller: buffers an AXI-stream packet in a small FIFO and drives the
// memory write stream with auto-incrementing addresses, packet completion and wrap tracking.
module mem_write_ctrl #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                 s01_axis_aclk,
   input  logic                 s01_axis_aresetn,
   mem_write_ctrl_if.slave      bus,
   input  logic                 addr_clr,
   output logic                 pkt_done,
   output logic [15:0]          pkt_count,
   output logic                 wrap_flag
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
      logic                  last;
   } beat_t;

   typedef enum logic {IDLE, BURST} state_t;

   beat_t             mem [FIFO_DEPTH];
   beat_t             head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full, empty, push, pop;
   logic [ADDR_WIDTH-1:0] addr_q;
   state_t            state_q, state_d;
   logic              done_d;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign push  = bus.s01_axis_tvalid && !full;
   assign pop   = !empty && bus.m01_axis_tready;
   assign head  = mem[rd_ptr];

   assign bus.s01_axis_tready   = !full;
   assign bus.m01_axis_tvalid   = !empty;
   assign bus.m01_axis_wr_en    = !empty;
   assign bus.m01_axis_wr_addr  = addr_q;
   // Head fields are masked while empty so the stale storage never shows on the bus.
   assign bus.m01_axis_wr_tdata = empty ? '0 : head.data;
   assign bus.m01_axis_tstrb    = empty ? '0 : head.strb;
   assign bus.m01_axis_tlast    = !empty && head.last;

   // NOTE: storage has no reset; only pointers and count need one, and leaving the array
   // unreset lets it map onto plain flops or distributed RAM.
   always_ff @(posedge s01_axis_aclk) begin
      if (push) mem[wr_ptr] <= '{data: bus.s01_axis_tdata, strb: bus.s01_axis_tstrb,
                                 last: bus.s01_axis_tlast};
   end

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         addr_q    <= BASE_ADDR;
         wrap_flag <= 1'b0;
      end else if (addr_clr) begin
         addr_q    <= BASE_ADDR;
         wrap_flag <= 1'b0;
      end else if (pop) begin
         addr_q <= addr_q + ADDR_WIDTH'(1);
         if (&addr_q) wrap_flag <= 1'b1;
      end
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         state_q   <= IDLE;
         pkt_done  <= 1'b0;
         pkt_count <= '0;
      end else begin
         state_q  <= state_d;
         pkt_done <= done_d;
         if (done_d) pkt_count <= pkt_count + 16'd1;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (pop) begin
         if (head.last) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = BURST;
         end
      end
   end
endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl: one instance at BASE_ADDR=0 and one at 0xFFE for the
// address wrap cases; all expected values are hand-computed constants.
module tb_mem_write_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr0 = 1'b0, clr1 = 1'b0;
   logic        done0, done1, wrap0, wrap1;
   logic [15:0] cnt0, cnt1;
   int          n_checks = 0;
   int          n_errors = 0;

   mem_write_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) ia ();
   mem_write_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) ib ();

   mem_write_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(12'h000), .FIFO_DEPTH(4)) dut0 (
      .s01_axis_aclk(clk), .s01_axis_aresetn(rst_n), .bus(ia), .addr_clr(clr0),
      .pkt_done(done0), .pkt_count(cnt0), .wrap_flag(wrap0));

   mem_write_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(12'hFFE), .FIFO_DEPTH(4)) dut1 (
      .s01_axis_aclk(clk), .s01_axis_aresetn(rst_n), .bus(ib), .addr_clr(clr1),
      .pkt_done(done1), .pkt_count(cnt1), .wrap_flag(wrap1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat on ia and holds it until the edge that accepts it.
   task automatic send_beat(input logic [31:0] data, input logic last);
      logic ok = 1'b0;
      ia.s01_axis_tvalid = 1'b1;
      ia.s01_axis_tdata  = data;
      ia.s01_axis_tstrb  = 4'hF;
      ia.s01_axis_tlast  = last;
      for (int c = 0; c < 50; c++) begin
         ok = ia.s01_axis_tready;
         tick();
         if (ok) break;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      ia.s01_axis_tvalid = 1'b0;
      ia.s01_axis_tlast  = 1'b0;
   endtask

   initial begin
      ia.s01_axis_tdata = '0; ia.s01_axis_tstrb = '0; ia.s01_axis_tvalid = 1'b0;
      ia.s01_axis_tlast = 1'b0; ia.m01_axis_tready = 1'b0;
      ib.s01_axis_tdata = '0; ib.s01_axis_tstrb = '0; ib.s01_axis_tvalid = 1'b0;
      ib.s01_axis_tlast = 1'b0; ib.m01_axis_tready = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_tready", ia.s01_axis_tready, 1);
      check("rst_tvalid", ia.m01_axis_tvalid, 0);
      check("rst_wr_en",  ia.m01_axis_wr_en, 0);
      check("rst_tlast",  ia.m01_axis_tlast, 0);
      check("rst_tdata",  ia.m01_axis_wr_tdata, 0);
      check("rst_tstrb",  ia.m01_axis_tstrb, 0);
      check("rst_addr",   ia.m01_axis_wr_addr, 0);
      check("rst_done",   done0, 0);
      check("rst_count",  cnt0, 0);
      check("rst_wrap",   wrap0, 0);
      check("rst_addr_b", ib.m01_axis_wr_addr, 12'hFFE);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Single-beat packet
      ia.s01_axis_tvalid = 1'b1; ia.s01_axis_tdata = 32'h55; ia.s01_axis_tstrb = 4'hF;
      ia.s01_axis_tlast = 1'b1; ia.m01_axis_tready = 1'b1;
      tick();
      ia.s01_axis_tvalid = 1'b0; ia.s01_axis_tlast = 1'b0;
      check("b1_tvalid", ia.m01_axis_tvalid, 1);
      check("b1_wr_en",  ia.m01_axis_wr_en, 1);
      check("b1_addr",   ia.m01_axis_wr_addr, 0);
      check("b1_data",   ia.m01_axis_wr_tdata, 32'h55);
      check("b1_strb",   ia.m01_axis_tstrb, 4'hF);
      check("b1_last",   ia.m01_axis_tlast, 1);
      check("b1_done0",  done0, 0);
      tick();
      check("b1_done",   done0, 1);
      check("b1_count",  cnt0, 1);
      check("b1_empty",  ia.m01_axis_tvalid, 0);
      check("b1_addr1",  ia.m01_axis_wr_addr, 1);
      tick();
      check("b1_done_off", done0, 0);
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      check("clr_addr", ia.m01_axis_wr_addr, 0);

      // 8-beat packet against a stalled memory, then released
      ia.m01_axis_tready = 1'b0;
      for (int i = 1; i <= 4; i++) send_beat(32'(i), 1'b0);
      check("full_tready", ia.s01_axis_tready, 0);
      check("full_head",   ia.m01_axis_wr_tdata, 1);
      tick(); tick();
      check("hold_data", ia.m01_axis_wr_tdata, 1);
      check("hold_addr", ia.m01_axis_wr_addr, 0);
      check("hold_valid", ia.m01_axis_tvalid, 1);
      fork
         begin
            for (int i = 5; i <= 8; i++) send_beat(32'(i), i == 8);
         end
         begin
            int n;
            int cyc;
            n = 0; cyc = 0;
            ia.m01_axis_tready = 1'b1;
            while (n < 8 && cyc < 40) begin
               if (ia.m01_axis_tvalid) begin
                  check("b8_addr", ia.m01_axis_wr_addr, n);
                  check("b8_data", ia.m01_axis_wr_tdata, n + 1);
                  check("b8_last", ia.m01_axis_tlast, n == 7);
                  n++;
               end
               tick();
               cyc++;
            end
            check("b8_beats",  n, 8);
            check("b8_cycles", cyc, 8);
         end
      join
      check("b8_done",  done0, 1);
      check("b8_count", cnt0, 2);

      // addr_clr on the same edge as a pop
      ia.m01_axis_tready = 1'b0;
      send_beat(32'hA1, 1'b0);
      send_beat(32'hB2, 1'b1);
      check("cp_head", ia.m01_axis_wr_tdata, 32'hA1);
      check("cp_addr0", ia.m01_axis_wr_addr, 8);
      ia.m01_axis_tready = 1'b1;
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      check("cp_addr", ia.m01_axis_wr_addr, 0);
      check("cp_data", ia.m01_axis_wr_tdata, 32'hB2);
      check("cp_valid", ia.m01_axis_tvalid, 1);
      tick();
      check("cp_addr1", ia.m01_axis_wr_addr, 1);
      check("cp_done",  done0, 1);
      check("cp_count", cnt0, 3);
      ia.m01_axis_tready = 1'b0;

      // Address wrap on the BASE_ADDR=0xFFE instance
      ib.m01_axis_tready = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               logic ok = 1'b0;
               ib.s01_axis_tvalid = 1'b1;
               ib.s01_axis_tdata  = 32'h100 + 32'(i);
               ib.s01_axis_tstrb  = 4'hF;
               ib.s01_axis_tlast  = (i == 3);
               for (int c = 0; c < 20; c++) begin
                  ok = ib.s01_axis_tready;
                  tick();
                  if (ok) break;
               end
               if (!ok) check("wrap_send_timeout", 32'd0, 32'd1);
            end
            ib.s01_axis_tvalid = 1'b0;
            ib.s01_axis_tlast  = 1'b0;
         end
         begin
            logic [11:0] exp_addr [4];
            int n;
            int cyc;
            exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF;
            exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
            n = 0; cyc = 0;
            while (n < 4 && cyc < 20) begin
               if (ib.m01_axis_tvalid) begin
                  check("wrap_addr", ib.m01_axis_wr_addr, exp_addr[n]);
                  check("wrap_data", ib.m01_axis_wr_tdata, 32'h100 + 32'(n));
                  n++;
               end
               tick();
               cyc++;
            end
            check("wrap_beats", n, 4);
         end
      join
      check("wrap_flag",  wrap1, 1);
      check("wrap_addr2", ib.m01_axis_wr_addr, 12'h002);
      check("wrap_count", cnt1, 1);
      check("wrap_flag_a", wrap0, 0);
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      check("wclr_addr", ib.m01_axis_wr_addr, 12'hFFE);
      check("wclr_flag", wrap1, 0);

      // Reset in the middle of a 5-beat packet
      send_beat(32'h61, 1'b0);
      send_beat(32'h62, 1'b0);
      check("mr_valid", ia.m01_axis_tvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_tvalid", ia.m01_axis_tvalid, 0);
      check("mr_wr_en",  ia.m01_axis_wr_en, 0);
      check("mr_tdata",  ia.m01_axis_wr_tdata, 0);
      check("mr_tlast",  ia.m01_axis_tlast, 0);
      check("mr_addr",   ia.m01_axis_wr_addr, 0);
      check("mr_tready", ia.s01_axis_tready, 1);
      check("mr_count",  cnt0, 0);
      check("mr_done",   done0, 0);
      @(negedge clk) rst_n = 1'b1;
      ia.m01_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mr_no_done", done0, 0);
         check("mr_no_beat", ia.m01_axis_tvalid, 0);
      end
      check("mr_count_after", cnt0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
